// File: rtl/mfi_retire_sequencer.sv
// mfi_retire_sequencer
//   Merges two MFI retirement lanes from a dual-issue core into one
//   oldest-first MFI stream. Entries that cannot be emitted this cycle wait
//   in a DEPTH-entry FIFO behind a single output register.
//
// Ports
//   clock, reset_n            rising-edge clock, async active-low reset
//   l{0,1}_valid/_order       lane retirement valid and instruction order
//   l{0,1}_src{1,2,3}_addr,
//   l{0,1}_dest_addr          lane register addresses
//   check_at                  order at which `check` pulses (quasi-static)
//   mfi_valid, mfi_order,
//   mfi_src{1,2,3}_addr,
//   mfi_dest_addr             serialized retirement (fields hold when idle)
//   check                     emitted order equals check_at
//   overflow                  sticky: an entry was dropped
//   order_err                 sticky: non-consecutive emission or equal lane orders
//   fill                      FIFO occupancy
module mfi_retire_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64,
  parameter int REG_W   = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     l0_valid,
  input  logic [ORDER_W-1:0]       l0_order,
  input  logic [REG_W-1:0]         l0_src1_addr,
  input  logic [REG_W-1:0]         l0_src2_addr,
  input  logic [REG_W-1:0]         l0_src3_addr,
  input  logic [REG_W-1:0]         l0_dest_addr,
  input  logic                     l1_valid,
  input  logic [ORDER_W-1:0]       l1_order,
  input  logic [REG_W-1:0]         l1_src1_addr,
  input  logic [REG_W-1:0]         l1_src2_addr,
  input  logic [REG_W-1:0]         l1_src3_addr,
  input  logic [REG_W-1:0]         l1_dest_addr,
  input  logic [ORDER_W-1:0]       check_at,
  output logic                     mfi_valid,
  output logic [ORDER_W-1:0]       mfi_order,
  output logic [REG_W-1:0]         mfi_src1_addr,
  output logic [REG_W-1:0]         mfi_src2_addr,
  output logic [REG_W-1:0]         mfi_src3_addr,
  output logic [REG_W-1:0]         mfi_dest_addr,
  output logic                     check,
  output logic                     overflow,
  output logic                     order_err,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ORDER_W + 4*REG_W;
  localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
  localparam logic [ORDER_W-1:0] ONE_O   = ORDER_W'(1);
  localparam logic [AW-1:0]      ONE_A   = AW'(1);

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [EW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_rd, r_wr;
  logic [CW-1:0]      r_cnt;
  logic [EW-1:0]      r_out;
  logic               r_vld, r_ovf, r_err, r_have;
  logic [ORDER_W-1:0] r_last;

  logic [EW-1:0]      w_l0, w_l1, w_first, w_second, w_emit, w_p0;
  logic [ORDER_W-1:0] w_emit_ord;
  logic               w_swap, w_first_v, w_second_v, w_ne, w_emit_v;
  logic               w_eq, w_gap, w_ovf;
  logic [CW-1:0]      w_nreq, w_space, w_npush;

  assign w_l0 = {l0_order, l0_src1_addr, l0_src2_addr, l0_src3_addr, l0_dest_addr};
  assign w_l1 = {l1_order, l1_src1_addr, l1_src2_addr, l1_src3_addr, l1_dest_addr};

  // Sort the incoming lanes: lane1 goes first only when strictly older.
  assign w_swap     = l0_valid && l1_valid && (l1_order < l0_order);
  assign w_first_v  = l0_valid || l1_valid;
  assign w_second_v = l0_valid && l1_valid;
  assign w_first    = (w_swap || !l0_valid) ? w_l1 : w_l0;
  assign w_second   = w_swap ? w_l0 : w_l1;
  assign w_eq       = l0_valid && l1_valid && (l0_order == l1_order);

  // FIFO contents are always older than the lanes, so the head wins if present.
  assign w_ne       = (r_cnt != '0);
  assign w_emit_v   = w_ne || w_first_v;
  assign w_emit     = w_ne ? r_mem[r_rd] : w_first;
  assign w_emit_ord = w_emit[EW-1 -: ORDER_W];

  // Leftover candidates: both lanes if the head was emitted, else only the younger.
  assign w_p0    = w_ne ? w_first : w_second;
  assign w_nreq  = w_ne ? (CW'(w_first_v) + CW'(w_second_v)) : CW'(w_second_v);
  assign w_space = DEPTH_C - r_cnt + CW'(w_ne);
  assign w_ovf   = (w_nreq > w_space);
  // Truncating to the free space drops the youngest candidate first.
  assign w_npush = w_ovf ? w_space : w_nreq;

  assign w_gap = r_have && w_emit_v && (w_emit_ord != r_last + ONE_O);

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_npush != '0 && AW'(i) == r_wr)
        r_mem[i] <= w_p0;
      else if (w_npush == CW'(2) && AW'(i) == r_wr + ONE_A)
        r_mem[i] <= w_second;
    end
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_have <= 1'b0;
      r_last <= '0;
    end else begin
      r_vld <= w_emit_v;
      if (w_emit_v) begin
        r_out  <= w_emit;
        r_have <= 1'b1;
        r_last <= w_emit_ord;
      end
      if (w_ne) r_rd <= r_rd + ONE_A;
      r_wr  <= r_wr + AW'(w_npush);
      r_cnt <= r_cnt - CW'(w_ne) + w_npush;
      if (w_ovf)         r_ovf <= 1'b1;
      if (w_eq || w_gap) r_err <= 1'b1;
    end
  end

  assign mfi_valid     = r_vld;
  assign mfi_order     = r_out[EW-1 -: ORDER_W];
  assign mfi_src1_addr = r_out[4*REG_W-1 -: REG_W];
  assign mfi_src2_addr = r_out[3*REG_W-1 -: REG_W];
  assign mfi_src3_addr = r_out[2*REG_W-1 -: REG_W];
  assign mfi_dest_addr = r_out[REG_W-1:0];
  assign check         = r_vld && (mfi_order == check_at);
  assign overflow      = r_ovf;
  assign order_err     = r_err;
  assign fill          = r_cnt;

endmodule

// File: tb/tb_mfi_retire_sequencer.sv
// Randomized + directed bench for mfi_retire_sequencer against a queue model:
// candidates = pending entries followed by sorted lanes, oldest one emitted,
// rest kept up to DEPTH with the youngest dropped.
module tb_mfi_retire_sequencer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        l0_valid = 1'b0, l1_valid = 1'b0;
  logic [63:0] l0_order = '0, l1_order = '0;
  logic [4:0]  l0_src1_addr = '0, l0_src2_addr = '0, l0_src3_addr = '0, l0_dest_addr = '0;
  logic [4:0]  l1_src1_addr = '0, l1_src2_addr = '0, l1_src3_addr = '0, l1_dest_addr = '0;
  logic [63:0] check_at = 64'd3;
  logic        mfi_valid, check, overflow, order_err;
  logic [63:0] mfi_order;
  logic [4:0]  mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr;
  logic [2:0]  fill;

  mfi_retire_sequencer #(.DEPTH(DEPTH), .ORDER_W(64), .REG_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .l0_valid(l0_valid), .l0_order(l0_order),
    .l0_src1_addr(l0_src1_addr), .l0_src2_addr(l0_src2_addr),
    .l0_src3_addr(l0_src3_addr), .l0_dest_addr(l0_dest_addr),
    .l1_valid(l1_valid), .l1_order(l1_order),
    .l1_src1_addr(l1_src1_addr), .l1_src2_addr(l1_src2_addr),
    .l1_src3_addr(l1_src3_addr), .l1_dest_addr(l1_dest_addr),
    .check_at(check_at),
    .mfi_valid(mfi_valid), .mfi_order(mfi_order),
    .mfi_src1_addr(mfi_src1_addr), .mfi_src2_addr(mfi_src2_addr),
    .mfi_src3_addr(mfi_src3_addr), .mfi_dest_addr(mfi_dest_addr),
    .check(check), .overflow(overflow), .order_err(order_err), .fill(fill)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] ord;
    logic [19:0] a;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_out;
  logic        m_vld, m_ovf, m_err, m_have;
  logic [63:0] m_last;
  int          n_tot = 0, n_bad = 0, n_pulse = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = '{ord: 64'd0, a: 20'd0};
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_have = 1'b0;
    m_last = 64'd0;
  endtask

  task automatic model_step();
    ent_t cand[$];
    ent_t e0, e1;
    cand = mq;
    e0 = '{ord: l0_order, a: {l0_src1_addr, l0_src2_addr, l0_src3_addr, l0_dest_addr}};
    e1 = '{ord: l1_order, a: {l1_src1_addr, l1_src2_addr, l1_src3_addr, l1_dest_addr}};
    if (l0_valid && l1_valid) begin
      if (l0_order == l1_order) m_err = 1'b1;
      if (l1_order < l0_order) begin cand.push_back(e1); cand.push_back(e0); end
      else                     begin cand.push_back(e0); cand.push_back(e1); end
    end else if (l0_valid) cand.push_back(e0);
    else if (l1_valid)     cand.push_back(e1);
    if (cand.size() > 0) begin
      m_out = cand.pop_front();
      m_vld = 1'b1;
      if (m_have && m_out.ord != m_last + 64'd1) m_err = 1'b1;
      m_have = 1'b1;
      m_last = m_out.ord;
    end else m_vld = 1'b0;
    if (cand.size() > DEPTH) begin
      m_ovf = 1'b1;
      while (cand.size() > DEPTH) void'(cand.pop_back());
    end
    mq = cand;
  endtask

  task automatic compare();
    chk("valid",     64'(mfi_valid), 64'(m_vld));
    chk("order",     mfi_order, m_out.ord);
    chk("addr",      64'({mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr}), 64'(m_out.a));
    chk("check",     64'(check), 64'(m_vld && (m_out.ord == check_at)));
    chk("overflow",  64'(overflow), 64'(m_ovf));
    chk("order_err", 64'(order_err), 64'(m_err));
    chk("fill",      64'(fill), 64'(mq.size()));
    if (check) n_pulse++;
  endtask

  task automatic cyc(input logic v0, input logic [63:0] o0, input logic v1, input logic [63:0] o1);
    logic [19:0] a0, a1;
    a0 = 20'($urandom);
    a1 = 20'($urandom);
    l0_valid = v0; l0_order = o0;
    {l0_src1_addr, l0_src2_addr, l0_src3_addr, l0_dest_addr} = a0;
    l1_valid = v1; l1_order = o1;
    {l1_src1_addr, l1_src2_addr, l1_src3_addr, l1_dest_addr} = a1;
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 64'd0);
  endtask

  // Asynchronous assert checked immediately, then held across two edges.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(mfi_valid), 64'd0);
    chk("rst_order", mfi_order, 64'd0);
    chk("rst_check", 64'(check), 64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    chk("rst_err",   64'(order_err), 64'd0);
    chk("rst_fill",  64'(fill), 64'd0);
    model_reset();
    l0_valid = 1'b0;
    l1_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
  endtask

  initial begin
    logic [63:0] nxt;
    int r;
    model_reset();
    #1;
    do_reset();

    // Lane0 only, consecutive orders.
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'(i), 1'b0, 64'd0);
    chk("p1_last", mfi_order, 64'd3);
    idle(2);
    // Same cycle, lane1 older.
    cyc(1'b1, 64'd5, 1'b1, 64'd4);
    chk("p2_first", mfi_order, 64'd4);
    chk("p2_fill", 64'(fill), 64'd1);
    idle(2);
    chk("p2_err", 64'(order_err), 64'd0);

    // Check pulse at check_at=3.
    do_reset();
    check_at = 64'd3;
    n_pulse = 0;
    for (int i = 0; i < 6; i++) cyc(1'b1, 64'(i), 1'b0, 64'd0);
    idle(1);
    chk("pulses", 64'(n_pulse), 64'd1);
    // Gap: ... 5, then 7 emitted.
    cyc(1'b1, 64'd7, 1'b0, 64'd0);
    chk("gap_err", 64'(order_err), 64'd1);

    // Equal lane orders.
    do_reset();
    cyc(1'b1, 64'd3, 1'b1, 64'd3);
    chk("eq_err", 64'(order_err), 64'd1);
    idle(2);

    // Reset mid-burst with fill=3, then re-baseline at 100.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'(100 + 2*i), 1'b1, 64'(101 + 2*i));
    chk("burst_fill", 64'(fill), 64'd3);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'(100 + i), 1'b0, 64'd0);
    chk("rebase_err", 64'(order_err), 64'd0);
    chk("rebase_ord", mfi_order, 64'd103);

    // Overflow: five dual cycles into DEPTH=4, then an order past the drop.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'(2*i), 1'b1, 64'(2*i + 1));
    chk("ovf_set", 64'(overflow), 64'd1);
    idle(4);
    chk("ovf_noerr", 64'(order_err), 64'd0);
    cyc(1'b1, 64'd10, 1'b0, 64'd0);
    chk("ovf_err", 64'(order_err), 64'd1);

    // Random traffic with occasional anomalies and resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      check_at = 64'($urandom_range(0, 60));
      nxt = 64'($urandom_range(0, 3)) + ((blk == 3) ? 64'hFFFF_FFFF_FFFF_FFF0 : 64'd0);
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 19);
        if (r < 6) idle(1);
        else if (r < 14) begin
          if ($urandom_range(0, 1) == 0) cyc(1'b1, nxt, 1'b0, 64'd0);
          else                           cyc(1'b0, 64'd0, 1'b1, nxt);
          nxt = nxt + 64'd1;
        end else if (r < 18) begin
          if ($urandom_range(0, 1) == 0) cyc(1'b1, nxt, 1'b1, nxt + 64'd1);
          else                           cyc(1'b1, nxt + 64'd1, 1'b1, nxt);
          nxt = nxt + 64'd2;
        end else if (r == 18) begin
          nxt = nxt + 64'd2;
          cyc(1'b1, nxt, 1'b0, 64'd0);
          nxt = nxt + 64'd1;
        end else begin
          cyc(1'b1, nxt, 1'b1, nxt);
          nxt = nxt + 64'd1;
        end
      end
      idle(6);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
